// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared constants for the LSU bus demultiplexer slice: address and
//            data widths, default MMIO window and slave index encoding.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Request / response field widths
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Default slave 1 (MMIO) address window
  localparam logic [ADDR_W-1:0] S1_BASE_DEF = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] S1_MASK_DEF = 32'hF000_0000;

  // Slave index encoding carried in the route tag
  localparam logic SLV_RAM  = 1'b0;
  localparam logic SLV_MMIO = 1'b1;

  // Address decode: 1 selects the MMIO slave
  function automatic logic route_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] mask
  );
    return ((addr & mask) == base);
  endfunction

endpackage
`default_nettype wire

// File: rtl/route_fifo.sv
`default_nettype none
// ============================================================================
// Module   : route_fifo
// Purpose  : 1-bit wide synchronous FIFO holding the slave index of every
//            outstanding request, oldest at the head. Occupancy is kept in a
//            dedicated counter so that full and empty need no extra pointer bit.
// Revision : 1.0 - initial release
// ============================================================================
module route_fifo #(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             din_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO or a pop from an empty one is ignored
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are meaningless while empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_demux.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_demux
// Purpose  : Steers the core's load/store request stream to the data RAM
//            (slave 0) or the MMIO block (slave 1) by address, and merges the
//            slave responses back to the core strictly in request order.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_demux
  import bus_pkg::*;
#(
  parameter int                MAX_OUTSTANDING = 4,
  parameter logic [ADDR_W-1:0] S1_BASE         = S1_BASE_DEF,
  parameter logic [ADDR_W-1:0] S1_MASK         = S1_MASK_DEF,
  localparam int               CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              clk,
  input  logic              rst,
  // Core request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  // Core response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  // Slave requests
  output logic              s0_req_valid,
  output logic              s1_req_valid,
  input  logic              s0_req_ready,
  input  logic              s1_req_ready,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic [DATA_W-1:0] s_req_wdata,
  output logic              s_req_we,
  output logic [BE_W-1:0]   s_req_be,
  // Slave responses
  input  logic              s0_rsp_valid,
  input  logic              s1_rsp_valid,
  output logic              s0_rsp_ready,
  output logic              s1_rsp_ready,
  input  logic [DATA_W-1:0] s0_rsp_rdata,
  input  logic [DATA_W-1:0] s1_rsp_rdata,
  // Status
  output logic [CNT_W-1:0]  outstanding,
  output logic              err_stray
);

  logic             sel;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             head_rsp_valid;
  logic             err_stray_q, err_stray_d;

  // ---------------------------------------------------------------------------
  // Request path: purely combinational, no added latency
  // ---------------------------------------------------------------------------
  assign sel = route_sel(req_addr, S1_BASE, S1_MASK);

  // Full blocks new requests even when a response pops in the same cycle;
  // this keeps req_ready independent of the response handshake.
  assign s0_req_valid = req_valid & (sel == SLV_RAM)  & ~fifo_full & ~rst;
  assign s1_req_valid = req_valid & (sel == SLV_MMIO) & ~fifo_full & ~rst;
  assign req_ready    = (sel ? s1_req_ready : s0_req_ready) & ~fifo_full & ~rst;

  assign s_req_addr   = req_addr;
  assign s_req_wdata  = req_wdata;
  assign s_req_we     = req_we;
  assign s_req_be     = req_be;

  assign fifo_push    = req_valid & req_ready;

  // ---------------------------------------------------------------------------
  // Route tag FIFO: remembers which slave owes the next response
  // ---------------------------------------------------------------------------
  route_fifo #(
    .DEPTH   (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (sel),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign outstanding = fifo_count;

  // ---------------------------------------------------------------------------
  // Response path: only the slave named by the head tag is listened to; the
  // other slave's response is left waiting on its own valid/ready pair.
  // ---------------------------------------------------------------------------
  assign head_rsp_valid = (fifo_head == SLV_MMIO) ? s1_rsp_valid : s0_rsp_valid;

  assign rsp_valid    = ~fifo_empty & head_rsp_valid & ~rst;
  assign rsp_rdata    = fifo_empty ? '0 :
                        ((fifo_head == SLV_MMIO) ? s1_rsp_rdata : s0_rsp_rdata);
  assign s0_rsp_ready = rsp_ready & ~fifo_empty & (fifo_head == SLV_RAM)  & ~rst;
  assign s1_rsp_ready = rsp_ready & ~fifo_empty & (fifo_head == SLV_MMIO) & ~rst;

  assign fifo_pop     = rsp_valid & rsp_ready;

  // ---------------------------------------------------------------------------
  // Stray response detection: any slave response with nothing outstanding
  // ---------------------------------------------------------------------------
  // Sticky set; only reset clears it
  always_comb begin
    err_stray_d = err_stray_q | (fifo_empty & (s0_rsp_valid | s1_rsp_valid));
  end

  // Stray flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_stray_q <= 1'b0;
    end else begin
      err_stray_q <= err_stray_d;
    end
  end

  assign err_stray = err_stray_q;

endmodule
`default_nettype wire

// File: doc/lsu_bus_demux.md
Name: lsu_bus_demux

Overview:
- Sequential 1-to-2 bus demultiplexer; the steering counterpart of the datapath 2:1 selects.
- Takes the core's single load/store request stream and routes each request, by address, to slave 0 (data RAM) or slave 1 (MMIO).
- Merges the slave responses back to the core strictly in request order.
- A small route-tag FIFO tracks outstanding requests.

Parameters:
- MAX_OUTSTANDING, 4, depth of the route FIFO; power of two, at least 2.
- S1_BASE, 32'h1000_0000, base address of the slave 1 window.
- S1_MASK, 32'hF000_0000, address bits compared against S1_BASE.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_we  in  1  1 = store, 0 = load.
- req_be  in  4  byte enables.
- rsp_valid  out  1  response to core valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load data; don't-care for stores.
- s0_req_valid, s1_req_valid  out  1  request valid to slave N.
- s0_req_ready, s1_req_ready  in  1  slave N accepts request.
- s_req_addr, s_req_wdata  out  32  shared copy of req_addr / req_wdata.
- s_req_we  out  1  shared copy of req_we.
- s_req_be  out  4  shared copy of req_be.
- s0_rsp_valid, s1_rsp_valid  in  1  slave N response valid.
- s0_rsp_ready, s1_rsp_ready  out  1  demux consumes slave N response.
- s0_rsp_rdata, s1_rsp_rdata  in  32  slave N read data.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current route FIFO occupancy.
- err_stray  out  1  sticky flag: a slave offered a response with nothing outstanding.

Behaviour:
- Route decode: sel = ((req_addr & S1_MASK) == S1_BASE); 1 selects slave 1.
- Request path is combinational, zero added latency:
  - sN_req_valid = req_valid & (sel==N) & !full & !rst.
  - req_ready = s{sel}_req_ready & !full & !rst.
- Accept = req_valid & req_ready. On accept, push sel into the route FIFO.
- Full blocks new requests even if a pop occurs in the same cycle. This is a decided simplification.
- Every accepted request, load or store, receives exactly one response from its slave.
- Slaves respond no earlier than the cycle after acceptance.
- Each slave returns its own responses in order.
- Response path is combinational. With head = FIFO head tag:
  - rsp_valid = !empty & s{head}_rsp_valid.
  - rsp_rdata = s{head}_rsp_rdata; 32'h0 when empty.
  - sN_rsp_ready = rsp_ready & !empty & (head==N).
- Pop on rsp_valid & rsp_ready.
- A response from the non-head slave is held, not consumed, until its tag reaches the head. Responses are never reordered.
- Simultaneous push and pop when not full: occupancy unchanged, pointers both advance.
- Pointers wrap modulo MAX_OUTSTANDING. Occupancy is held in a separate counter, range 0..MAX_OUTSTANDING.
- err_stray sets on any clock where empty & (s0_rsp_valid | s1_rsp_valid). It clears only on reset.
- Reset (async assert, synchronous-safe deassert by the system):
  - Pointers, occupancy and err_stray go to 0.
  - While rst is high: req_ready=0, sN_req_valid=0, rsp_valid=0, sN_rsp_ready=0, outstanding=0.
- Reset mid-transaction discards all outstanding tags. Slave-side cleanup is the responsibility of the system reset.

Decomposition:
- Shared package (bus_pkg): S1_BASE/S1_MASK defaults, slave index constants SLV_RAM=0 and SLV_MMIO=1, request/response field widths.
- Natural sub-module route_fifo: 1-bit-wide synchronous FIFO with push, pop, head, full, empty, count.
  - Parameterised by MAX_OUTSTANDING.
  - Same clk and asynchronous active-high rst.

Test Plan:
- Load to 32'h0000_0040, s0 ready, s0 responds next cycle with 32'hDEAD_BEEF -> s0_req_valid pulses, outstanding 1 then 0, rsp_rdata=32'hDEAD_BEEF, s1 untouched.
- Load to 32'h1000_0004 (s1) then 32'h0000_0008 (s0); s0 responds first with 32'h2222, s1 two cycles later with 32'h1111 -> core sees 32'h1111 then 32'h2222; s0_rsp_ready stays low until the s1 response pops.
- Issue 4 back-to-back requests with no responses (MAX_OUTSTANDING=4) -> outstanding=4, req_ready=0 on the 5th. Return one response -> req_ready reasserts the cycle after the pop.
- Hold rsp_ready=0 for 3 cycles with s0_rsp_valid=1 -> rsp_valid held, s0_rsp_ready=0, no pop. Raise rsp_ready -> single pop.
- Drive s1_rsp_valid=1 with FIFO empty -> err_stray=1 next edge and stays 1; rsp_valid=0; only rst clears it.
- Assert rst asynchronously with 2 outstanding -> outputs zero immediately, outstanding=0. After release, a fresh request routes normally.
